// File: rtl/vrased_rst_ctl_if.sv
// Bundle between the VRASED access-control monitors/core and the central reset controller.
// master = requesters and reset consumers, slave = vrased_rst_ctl.
interface vrased_rst_ctl_if #(
  parameter int NUM_SRC = 4
);
  logic [15:0]        pc;
  logic [NUM_SRC-1:0] req;
  logic               cause_clr;
  logic               sys_rst;
  logic               busy;
  logic [NUM_SRC-1:0] rst_cause;
  logic [7:0]         viol_cnt;

  modport master (
    output pc, req, cause_clr,
    input  sys_rst, busy, rst_cause, viol_cnt
  );

  modport slave (
    input  pc, req, cause_clr,
    output sys_rst, busy, rst_cause, viol_cnt
  );
endinterface

// File: rtl/vrased_rst_ctl.sv
// Merges monitor reset requests into one registered sys_rst with a minimum pulse, held until pc hits
// the reset handler; 1-cycle latency, no backpressure. Cause/violation logging built only with VRASED_RST_CAUSE_EN.
module vrased_rst_ctl #(
  parameter int          NUM_SRC       = 4,
  parameter int          MIN_PULSE     = 8,
  parameter logic [15:0] RESET_HANDLER = 16'h0000
) (
  input  logic            clk,
  input  logic            rst,
  vrased_rst_ctl_if.slave bus
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ASSERT  = 2'd1;
  localparam logic [1:0] S_WAIT_PC = 2'd2;

  localparam logic [7:0] RELOAD = 8'(MIN_PULSE - 1);

  logic [1:0] state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       sys_rst_q, sys_rst_d;
  logic       busy_q, busy_d;
  logic       any_req;
  logic       enter_assert;

  assign any_req      = |bus.req;
  assign enter_assert = (state_q == S_IDLE) && any_req;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (any_req) begin
          state_d = S_ASSERT;
          cnt_d   = RELOAD;
        end
      end
      S_ASSERT: begin
        // A request during the pulse restarts the full minimum width.
        if (any_req) begin
          cnt_d = RELOAD;
        end else if (cnt_q == 8'd0) begin
          state_d = S_WAIT_PC;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_WAIT_PC: begin
        // A new request beats a coincident handler match.
        if (any_req) begin
          state_d = S_ASSERT;
          cnt_d   = RELOAD;
        end else if (bus.pc == RESET_HANDLER) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_ASSERT;
        cnt_d   = RELOAD;
      end
    endcase
    sys_rst_d = (state_d != S_IDLE);
    busy_d    = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_ASSERT;
      cnt_q     <= RELOAD;
      sys_rst_q <= 1'b1;
      busy_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sys_rst_q <= sys_rst_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.sys_rst = sys_rst_q;
  assign bus.busy    = busy_q;

`ifdef VRASED_RST_CAUSE_EN
  logic [NUM_SRC-1:0] cause_q, cause_d;
  logic [7:0]         viol_q, viol_d;

  always_comb begin
    // Clearing keeps requests arriving in the same cycle.
    cause_d = (bus.cause_clr ? '0 : cause_q) | bus.req;
    viol_d  = viol_q;
    if (enter_assert && (viol_q != 8'hFF)) begin
      viol_d = viol_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cause_q <= '0;
      viol_q  <= 8'd0;
    end else begin
      cause_q <= cause_d;
      viol_q  <= viol_d;
    end
  end

  assign bus.rst_cause = cause_q;
  assign bus.viol_cnt  = viol_q;
`else
  logic unused_cause_inputs;
  assign unused_cause_inputs = bus.cause_clr ^ enter_assert;

  assign bus.rst_cause = '0;
  assign bus.viol_cnt  = 8'd0;
`endif

endmodule

// File: tb/tb_vrased_rst_ctl.sv
// Directed bench for vrased_rst_ctl: cycle model feeds an expectation queue, plus fixed pulse-length checks.
module tb_vrased_rst_ctl;

`ifdef VRASED_RST_CAUSE_EN
  localparam bit CAUSE_EN = 1'b1;
`else
  localparam bit CAUSE_EN = 1'b0;
`endif

  localparam int MP = 8;

  typedef struct packed {
    logic       sys_rst;
    logic       busy;
    logic [3:0] cause;
    logic [7:0] viol;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   hi_cnt;

  // reference model state: 0 idle, 1 pulse, 2 waiting for handler
  int         m_st;
  int         m_cnt;
  logic [3:0] m_cause;
  logic [7:0] m_viol;

  vrased_rst_ctl_if #(.NUM_SRC(4)) bus ();

  vrased_rst_ctl #(
    .NUM_SRC      (4),
    .MIN_PULSE    (MP),
    .RESET_HANDLER(16'h0000)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, want);
    end
  endtask

  task automatic model_edge();
    bit any;
    any = (bus.req != 4'b0000);
    if (rst) begin
      m_st = 1; m_cnt = MP - 1; m_cause = 4'b0000; m_viol = 8'd0;
    end else begin
      if (CAUSE_EN) m_cause = (bus.cause_clr ? 4'b0000 : m_cause) | bus.req;
      if (m_st == 0) begin
        if (any) begin
          m_st = 1; m_cnt = MP - 1;
          if (CAUSE_EN && m_viol != 8'hFF) m_viol = m_viol + 8'd1;
        end
      end else if (m_st == 1) begin
        if (any) m_cnt = MP - 1;
        else if (m_cnt == 0) m_st = 2;
        else m_cnt = m_cnt - 1;
      end else begin
        if (any) begin m_st = 1; m_cnt = MP - 1; end
        else if (bus.pc == 16'h0000) m_st = 0;
      end
    end
  endtask

  task automatic step(input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      model_edge();
      e.sys_rst = (m_st != 0);
      e.busy    = (m_st != 0);
      e.cause   = m_cause;
      e.viol    = m_viol;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      check("sys_rst", 32'(bus.sys_rst), 32'(e.sys_rst));
      check("busy", 32'(bus.busy), 32'(e.busy));
      check("rst_cause", 32'(bus.rst_cause), 32'(e.cause));
      check("viol_cnt", 32'(bus.viol_cnt), 32'(e.viol));
      if (bus.sys_rst === 1'b1) hi_cnt++;
    end
  endtask

  function automatic logic [31:0] en(input logic [31:0] v);
    return CAUSE_EN ? v : 32'd0;
  endfunction

  initial begin
    rst = 1'b1; bus.req = 4'b0000; bus.pc = 16'h0000; bus.cause_clr = 1'b0;
    m_st = 0; m_cnt = 0; m_cause = 4'b0000; m_viol = 8'd0;
    @(negedge clk);

    // T1: reset pulse with pc already at the handler
    hi_cnt = 0;
    step(1);
    check("t1_reset_sys_rst", 32'(bus.sys_rst), 32'd1);
    rst = 1'b0;
    step(9);
    check("t1_pulse_len", 32'(hi_cnt), 32'd9);
    check("t1_released", 32'(bus.sys_rst), 32'd0);
    check("t1_viol", 32'(bus.viol_cnt), 32'd0);

    // T2: one-cycle request, core away from handler for 20 cycles
    hi_cnt = 0;
    bus.pc = 16'hE000; bus.req = 4'b0001;
    step(1);
    check("t2_rise", 32'(bus.sys_rst), 32'd1);
    bus.req = 4'b0000;
    step(19);
    bus.pc = 16'h0000;
    step(1);
    check("t2_pulse_len", 32'(hi_cnt), 32'd20);
    check("t2_released", 32'(bus.sys_rst), 32'd0);
    check("t2_cause", 32'(bus.rst_cause), en(32'h1));
    check("t2_viol", 32'(bus.viol_cnt), en(32'd1));

    // T3: retrigger from a second monitor during the pulse
    rst = 1'b1; step(1); rst = 1'b0; step(9);
    hi_cnt = 0;
    bus.req = 4'b0001; step(1);
    bus.req = 4'b0000; step(4);
    bus.req = 4'b0100; step(1);
    bus.req = 4'b0000; step(9);
    check("t3_pulse_len", 32'(hi_cnt), 32'd14);
    check("t3_released", 32'(bus.sys_rst), 32'd0);
    check("t3_cause", 32'(bus.rst_cause), en(32'h5));
    check("t3_viol", 32'(bus.viol_cnt), en(32'd1));

    // T4: request and handler match in the same WAIT_PC cycle
    bus.pc = 16'hE000; bus.req = 4'b0001; step(1);
    bus.req = 4'b0000; step(10);
    bus.pc = 16'h0000; bus.req = 4'b1000; step(1);
    check("t4_held", 32'(bus.sys_rst), 32'd1);
    check("t4_viol", 32'(bus.viol_cnt), en(32'd2));
    bus.req = 4'b0000; hi_cnt = 0; step(9);
    check("t4_pulse_len", 32'(hi_cnt), 32'd8);
    check("t4_released", 32'(bus.sys_rst), 32'd0);

    // T5: clear together with a fresh request, then saturate the counter
    bus.cause_clr = 1'b1; bus.req = 4'b0010; step(1);
    bus.cause_clr = 1'b0; bus.req = 4'b0000;
    check("t5_cause_clr", 32'(bus.rst_cause), en(32'h2));
    step(9);
    for (int k = 0; k < 260; k++) begin
      bus.req = 4'b0001; step(1);
      bus.req = 4'b0000; step(9);
    end
    check("t5_viol_sat", 32'(bus.viol_cnt), en(32'hFF));

    // Reset during WAIT_PC restarts a full pulse and clears the log
    bus.pc = 16'hE000; bus.req = 4'b0100; step(1);
    bus.req = 4'b0000; step(10);
    rst = 1'b1; step(1); rst = 1'b0;
    bus.pc = 16'h0000; hi_cnt = 0; step(9);
    check("rst_mid_pulse_len", 32'(hi_cnt), 32'd8);
    check("rst_mid_viol", 32'(bus.viol_cnt), 32'd0);
    check("rst_mid_released", 32'(bus.sys_rst), 32'd0);

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
